tlb_ctrl: RTL and testbench



---
 rtl/tlb_pkg.sv | 47 ++++
 rtl/tlb_req_arb.sv | 45 ++++
 rtl/tlb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tlb_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the joint-TLB arbiter/sequencer.
package tlb_pkg;

   typedef enum logic [1:0] {
      TLBP  = 2'b00,
      TLBR  = 2'b01,
      TLBWI = 2'b10,
      TLBWR = 2'b11
   } op_e;

   localparam logic [1:0] REF_FETCH = 2'b00;
   localparam logic [1:0] REF_LOAD  = 2'b01;
   localparam logic [1:0] REF_STORE = 2'b10;

   localparam logic [1:0] EXC_NONE    = 2'b00;
   localparam logic [1:0] EXC_REFILL  = 2'b01;
   localparam logic [1:0] EXC_INVALID = 2'b10;
   localparam logic [1:0] EXC_MOD     = 2'b11;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      DRAIN   = 2'b01,
      OP_EXEC = 2'b10,
      OP_DONE = 2'b11
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Refill beats invalid beats modified; modified only matters for stores.
   function automatic logic [1:0] exc_code(input logic [1:0] reftype,
                                           input logic       refill,
                                           input logic       invalid,
                                           input logic       modified);
      if (refill)
         return EXC_REFILL;
      else if (invalid)
         return EXC_INVALID;
      else if (modified && (reftype == REF_STORE))
         return EXC_MOD;
      else
         return EXC_NONE;
   endfunction

endpackage

// File: rtl/tlb_req_arb.sv
// Fetch/data grant for the shared TLB lookup port. Data normally wins;
// a starve counter lets fetch through after STARVE_LIMIT data grants.
// STARVE_LIMIT must be at least 1.
module tlb_req_arb #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic block,
   output logic i_ack,
   output logic d_ack
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] sc;
   logic            starved;

   assign starved = (sc == SC_W'(STARVE_LIMIT));

   // Grant decision, combinational from the requests and the counter
   always_comb begin
      i_ack = 1'b0;
      d_ack = 1'b0;
      if (!block) begin
         if (d_req && !(i_req && starved))
            d_ack = 1'b1;
         else if (i_req)
            i_ack = 1'b1;
      end
   end

   // Starve counter: counts data grants taken while fetch is waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sc <= '0;
      else if (!i_req || i_ack)
         sc <= '0;
      else if (d_ack)
         sc <= sc + 1'b1;
   end

endmodule

// File: rtl/tlb_ctrl.sv
// Arbiter and sequencer for the single-port joint TLB: two-stage lookup
// pipeline shared by fetch and data, plus CP0 maintenance op sequencing.
//
// state   | meaning
// RUN     | lookups granted; op_valid blocks grants and starts an op
// DRAIN   | one cycle, last granted lookup leaves stage 1
// OP_EXEC | TLB driven for the op (write pulse / read index / probe)
// OP_DONE | op_done pulse, TLB read data stable for CP0
module tlb_ctrl
   import tlb_pkg::*;
#(
   parameter int NENTRY       = 32,
   parameter int IDX_W        = 5,
   parameter int STARVE_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [31:0]      i_vaddr,
   output logic             i_ack,
   output logic             i_rvalid,
   output logic [31:0]      i_paddr,
   output logic [1:0]       i_exc,
   input  logic             d_req,
   input  logic [31:0]      d_vaddr,
   input  logic             d_store,
   output logic             d_ack,
   output logic             d_rvalid,
   output logic [31:0]      d_paddr,
   output logic [1:0]       d_exc,
   input  logic             op_valid,
   input  logic [1:0]       op_code,
   input  logic [IDX_W-1:0] op_index,
   input  logic [IDX_W-1:0] op_random,
   input  logic [31:0]      op_entryhi,
   output logic             op_done,
   output logic [31:0]      probe_result,
   output logic [31:0]      tlb_vaddr,
   output logic [1:0]       tlb_reftype,
   input  logic [31:0]      tlb_paddr,
   input  logic             tlb_refill,
   input  logic             tlb_invalid,
   input  logic             tlb_modified,
   input  logic [IDX_W-1:0] tlb_hit_idx,
   output logic             tlb_we,
   output logic [IDX_W-1:0] tlb_idx
);

   // Index field of the probe result is sized from the entry count;
   // IDX_W has to agree with it for the result to be 32 bits wide.
   localparam int IDX_BITS = (NENTRY > 1) ? $clog2(NENTRY) : 1;

   state_e     state, state_nxt;
   op_e        op;
   logic       block;
   logic       s1_valid;
   owner_e     s1_owner;
   logic [1:0] lk_exc;

   assign op     = op_e'(op_code);
   assign lk_exc = exc_code(tlb_reftype, tlb_refill, tlb_invalid, tlb_modified);

   tlb_req_arb #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .i_req(i_req),
      .d_req(d_req),
      .block(block),
      .i_ack(i_ack),
      .d_ack(d_ack)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (op_valid) state_nxt = DRAIN;
         DRAIN:   state_nxt = OP_EXEC;
         OP_EXEC: state_nxt = OP_DONE;
         OP_DONE: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // FSM outputs: grant blocking and the completion pulse
   always_comb begin
      block   = 1'b1;
      op_done = 1'b0;
      case (state)
         RUN:     block = op_valid;
         OP_DONE: op_done = 1'b1;
         default: ;
      endcase
   end

   // Stage 1: granted lookup, or op set-up at the end of DRAIN so that
   // tlb_we/tlb_idx/tlb_vaddr are registered and valid during OP_EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_owner    <= OWN_I;
         tlb_vaddr   <= '0;
         tlb_reftype <= REF_FETCH;
         tlb_we      <= 1'b0;
         tlb_idx     <= '0;
      end else begin
         tlb_we   <= 1'b0;
         s1_valid <= i_ack | d_ack;
         if (i_ack) begin
            tlb_vaddr   <= i_vaddr;
            tlb_reftype <= REF_FETCH;
            s1_owner    <= OWN_I;
         end else if (d_ack) begin
            tlb_vaddr   <= d_vaddr;
            tlb_reftype <= d_store ? REF_STORE : REF_LOAD;
            s1_owner    <= OWN_D;
         end else if (state == DRAIN) begin
            tlb_idx <= (op == TLBWR) ? op_random : op_index;
            tlb_we  <= (op == TLBWI) || (op == TLBWR);
            if (op == TLBP) begin
               tlb_vaddr   <= op_entryhi;
               tlb_reftype <= REF_LOAD;
            end
         end
      end
   end

   // Stage 2: route the TLB response to its owner and pulse rvalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_paddr  <= '0;
         d_paddr  <= '0;
         i_exc    <= EXC_NONE;
         d_exc    <= EXC_NONE;
      end else begin
         i_rvalid <= s1_valid && (s1_owner == OWN_I);
         d_rvalid <= s1_valid && (s1_owner == OWN_D);
         if (s1_valid) begin
            if (s1_owner == OWN_I) begin
               i_paddr <= tlb_paddr;
               i_exc   <= lk_exc;
            end else begin
               d_paddr <= tlb_paddr;
               d_exc   <= lk_exc;
            end
         end
      end
   end

   // Probe result captured during OP_EXEC of a TLBP, held until the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         probe_result <= '0;
      else if ((state == OP_EXEC) && (op == TLBP))
         probe_result <= {tlb_refill, {(31 - IDX_BITS){1'b0}}, tlb_hit_idx};
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge. The TLB array is modelled
// as a fixed address remap (vaddr xor MAP) with flags driven per vector.
module tb_tlb_ctrl;

   localparam logic [31:0] MAP = 32'h1F80_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_store, op_valid;
   logic [31:0] i_vaddr, d_vaddr, op_entryhi;
   logic [1:0]  op_code;
   logic [4:0]  op_index, op_random, tlb_hit_idx;
   logic        tlb_refill, tlb_invalid, tlb_modified;
   logic        i_ack, i_rvalid, d_ack, d_rvalid, op_done, tlb_we;
   logic [31:0] i_paddr, d_paddr, probe_result, tlb_vaddr, tlb_paddr;
   logic [1:0]  i_exc, d_exc, tlb_reftype;
   logic [4:0]  tlb_idx;

   int n_vec = 0;
   int n_err = 0;

   assign tlb_paddr = tlb_vaddr ^ MAP;

   always #5 clk = ~clk;

   tlb_ctrl #(.NENTRY(32), .IDX_W(5), .STARVE_LIMIT(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req),
      .i_vaddr     (i_vaddr),
      .i_ack       (i_ack),
      .i_rvalid    (i_rvalid),
      .i_paddr     (i_paddr),
      .i_exc       (i_exc),
      .d_req       (d_req),
      .d_vaddr     (d_vaddr),
      .d_store     (d_store),
      .d_ack       (d_ack),
      .d_rvalid    (d_rvalid),
      .d_paddr     (d_paddr),
      .d_exc       (d_exc),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .op_index    (op_index),
      .op_random   (op_random),
      .op_entryhi  (op_entryhi),
      .op_done     (op_done),
      .probe_result(probe_result),
      .tlb_vaddr   (tlb_vaddr),
      .tlb_reftype (tlb_reftype),
      .tlb_paddr   (tlb_paddr),
      .tlb_refill  (tlb_refill),
      .tlb_invalid (tlb_invalid),
      .tlb_modified(tlb_modified),
      .tlb_hit_idx (tlb_hit_idx),
      .tlb_we      (tlb_we),
      .tlb_idx     (tlb_idx)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string pfx);
      chk({pfx, "_iack"}, 32'(i_ack), 0);
      chk({pfx, "_dack"}, 32'(d_ack), 0);
      chk({pfx, "_irv"}, 32'(i_rvalid), 0);
      chk({pfx, "_drv"}, 32'(d_rvalid), 0);
      chk({pfx, "_done"}, 32'(op_done), 0);
      chk({pfx, "_we"}, 32'(tlb_we), 0);
      chk({pfx, "_idx"}, 32'(tlb_idx), 0);
      chk({pfx, "_tva"}, tlb_vaddr, 0);
      chk({pfx, "_ref"}, 32'(tlb_reftype), 0);
      chk({pfx, "_ipa"}, i_paddr, 0);
      chk({pfx, "_dpa"}, d_paddr, 0);
      chk({pfx, "_iexc"}, 32'(i_exc), 0);
      chk({pfx, "_dexc"}, 32'(d_exc), 0);
      chk({pfx, "_probe"}, probe_result, 0);
   endtask

   // One isolated lookup with flags applied while it sits in stage 1
   task automatic lookup(input string tag, input logic is_d, input logic store,
                         input logic rf, input logic inv, input logic md,
                         input logic [1:0] exp_exc);
      logic [31:0] va;
      va = is_d ? 32'h0050_0040 : 32'h0040_0080;
      i_req = !is_d; d_req = is_d; d_store = store;
      i_vaddr = va; d_vaddr = va;
      @(negedge clk);
      chk({tag, "_ack"}, 32'(is_d ? d_ack : i_ack), 1);
      cyc();
      i_req = 1'b0; d_req = 1'b0;
      tlb_refill = rf; tlb_invalid = inv; tlb_modified = md;
      @(negedge clk);
      chk({tag, "_ref"}, 32'(tlb_reftype), is_d ? (store ? 32'd2 : 32'd1) : 32'd0);
      cyc();
      tlb_refill = 1'b0; tlb_invalid = 1'b0; tlb_modified = 1'b0;
      @(negedge clk);
      chk({tag, "_rv"}, 32'(is_d ? d_rvalid : i_rvalid), 1);
      chk({tag, "_exc"}, 32'(is_d ? d_exc : i_exc), 32'(exp_exc));
      chk({tag, "_pa"}, is_d ? d_paddr : i_paddr, va ^ MAP);
      cyc();
   endtask

   // Full CP0 op with no lookups in flight; starts at cycle N
   task automatic run_op(input string tag, input logic [1:0] code, input logic [4:0] idx,
                         input logic [4:0] rnd, input logic [31:0] ehi,
                         input logic [4:0] hit, input logic rf,
                         input logic exp_we, input logic chk_idx, input logic [4:0] exp_idx);
      op_valid = 1'b1; op_code = code; op_index = idx; op_random = rnd; op_entryhi = ehi;
      @(negedge clk);
      chk({tag, "_n_done"}, 32'(op_done), 0);
      cyc();
      @(negedge clk);
      chk({tag, "_n1_we"}, 32'(tlb_we), 0);
      chk({tag, "_n1_done"}, 32'(op_done), 0);
      cyc();
      tlb_hit_idx = hit; tlb_refill = rf;
      @(negedge clk);
      chk({tag, "_n2_we"}, 32'(tlb_we), 32'(exp_we));
      if (chk_idx) chk({tag, "_n2_idx"}, 32'(tlb_idx), 32'(exp_idx));
      if (code == 2'b00) begin
         chk({tag, "_n2_tva"}, tlb_vaddr, ehi);
         chk({tag, "_n2_ref"}, 32'(tlb_reftype), 1);
      end
      cyc();
      tlb_hit_idx = 5'd0; tlb_refill = 1'b0;
      @(negedge clk);
      chk({tag, "_n3_done"}, 32'(op_done), 1);
      chk({tag, "_n3_we"}, 32'(tlb_we), 0);
      if (chk_idx) chk({tag, "_n3_idx"}, 32'(tlb_idx), 32'(exp_idx));
      cyc();
      op_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_n4_done"}, 32'(op_done), 0);
      cyc();
   endtask

   logic        own_i [0:11];
   logic [31:0] exp_pa [0:11];

   initial begin
      logic [31:0] iv;
      logic        g_i;

      rst = 1'b1;
      i_req = 0; d_req = 0; d_store = 0; op_valid = 0;
      i_vaddr = 0; d_vaddr = 0; op_entryhi = 0; op_code = 0;
      op_index = 0; op_random = 0; tlb_hit_idx = 0;
      tlb_refill = 0; tlb_invalid = 0; tlb_modified = 0;

      // reset state
      @(negedge clk);
      check_idle("rst");
      cyc();
      rst = 1'b0;
      cyc();

      // single fetch
      i_req = 1'b1; i_vaddr = 32'h0040_1004;
      @(negedge clk);
      chk("sf_iack", 32'(i_ack), 1);
      chk("sf_dack", 32'(d_ack), 0);
      cyc();
      i_req = 1'b0;
      @(negedge clk);
      chk("sf_tva", tlb_vaddr, 32'h0040_1004);
      chk("sf_irv1", 32'(i_rvalid), 0);
      cyc();
      @(negedge clk);
      chk("sf_irv", 32'(i_rvalid), 1);
      chk("sf_ipa", i_paddr, 32'h1FC0_1004);
      chk("sf_iexc", 32'(i_exc), 0);
      chk("sf_drv", 32'(d_rvalid), 0);
      cyc();
      @(negedge clk);
      chk("sf_irv_drop", 32'(i_rvalid), 0);
      cyc();

      // starvation: both requesters for 10 cycles, D,D,D,I repeating
      iv = 32'h0040_0000;
      for (int k = 0; k < 12; k++) begin
         i_req = (k < 10); d_req = (k < 10);
         i_vaddr = iv; d_vaddr = 32'h0000_2000 + 32'(k * 4);
         g_i = ((k % 4) == 3);
         @(negedge clk);
         if (k < 10) begin
            chk("sv_iack", 32'(i_ack), 32'(g_i));
            chk("sv_dack", 32'(d_ack), 32'(!g_i));
            own_i[k]  = g_i;
            exp_pa[k] = (g_i ? iv : d_vaddr) ^ MAP;
         end
         if (k >= 2) begin
            chk("sv_irv", 32'(i_rvalid), 32'(own_i[k-2]));
            chk("sv_drv", 32'(d_rvalid), 32'(!own_i[k-2]));
            chk("sv_pa", own_i[k-2] ? i_paddr : d_paddr, exp_pa[k-2]);
            chk("sv_exc", 32'(own_i[k-2] ? i_exc : d_exc), 0);
         end
         cyc();
         if (g_i) iv = iv + 32'h10;
      end

      // exception priority
      lookup("ex_st_rf_md", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
      lookup("ex_st_md",    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
      lookup("ex_ld_md",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      lookup("ex_st_inv",   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
      lookup("ex_if_md",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      lookup("ex_if_inv",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);

      // TLBWR against back-to-back data lookups
      d_req = 1'b1; d_store = 1'b0; d_vaddr = 32'h0000_3000;
      @(negedge clk);
      chk("wr_a0", 32'(d_ack), 1);
      cyc();
      d_vaddr = 32'h0000_3004;
      @(negedge clk);
      chk("wr_a1", 32'(d_ack), 1);
      cyc();
      d_vaddr = 32'h0000_3008; i_req = 1'b1; i_vaddr = 32'h0040_4000;
      op_valid = 1'b1; op_code = 2'b11; op_index = 5'd3; op_random = 5'd17;
      @(negedge clk);
      chk("wr_n_iack", 32'(i_ack), 0);
      chk("wr_n_dack", 32'(d_ack), 0);
      chk("wr_n_drv", 32'(d_rvalid), 1);
      chk("wr_n_dpa", d_paddr, 32'h0000_3000 ^ MAP);
      chk("wr_n_we", 32'(tlb_we), 0);
      cyc();
      @(negedge clk);
      chk("wr_n1_acks", 32'({i_ack, d_ack}), 0);
      chk("wr_n1_drv", 32'(d_rvalid), 1);
      chk("wr_n1_dpa", d_paddr, 32'h0000_3004 ^ MAP);
      chk("wr_n1_we", 32'(tlb_we), 0);
      chk("wr_n1_done", 32'(op_done), 0);
      cyc();
      @(negedge clk);
      chk("wr_n2_we", 32'(tlb_we), 1);
      chk("wr_n2_idx", 32'(tlb_idx), 17);
      chk("wr_n2_acks", 32'({i_ack, d_ack}), 0);
      chk("wr_n2_drv", 32'(d_rvalid), 0);
      chk("wr_n2_done", 32'(op_done), 0);
      cyc();
      @(negedge clk);
      chk("wr_n3_done", 32'(op_done), 1);
      chk("wr_n3_we", 32'(tlb_we), 0);
      chk("wr_n3_acks", 32'({i_ack, d_ack}), 0);
      cyc();
      op_valid = 1'b0;
      @(negedge clk);
      chk("wr_n4_dack", 32'(d_ack), 1);
      chk("wr_n4_iack", 32'(i_ack), 0);
      chk("wr_n4_done", 32'(op_done), 0);
      cyc();
      i_req = 1'b0; d_req = 1'b0;
      cyc();
      cyc();

      // TLBP hit and miss, then TLBR leaves the probe result alone
      run_op("tp_hit", 2'b00, 5'd0, 5'd0, 32'h7FFF_E0AB, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("tp_hit_res", probe_result, 32'h0000_0009);
      run_op("tp_miss", 2'b00, 5'd0, 5'd0, 32'h7FFF_E0AB, 5'd21, 1'b1, 1'b0, 1'b0, 5'd0);
      chk("tp_miss_res", probe_result, 32'h8000_0015);
      run_op("tr", 2'b01, 5'd6, 5'd2, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 5'd6);
      chk("tr_probe_hold", probe_result, 32'h8000_0015);
      run_op("twi", 2'b10, 5'd5, 5'd2, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);

      // reset during OP_EXEC of a TLBWI
      op_valid = 1'b1; op_code = 2'b10; op_index = 5'd12;
      cyc();
      cyc();
      chk("rm_we_pre", 32'(tlb_we), 1);
      chk("rm_idx_pre", 32'(tlb_idx), 12);
      #2 rst = 1'b1;
      #1;
      chk("rm_we_async", 32'(tlb_we), 0);
      chk("rm_done_async", 32'(op_done), 0);
      op_valid = 1'b0;
      @(negedge clk);
      check_idle("rm");
      @(negedge clk);
      chk("rm_n3_done", 32'(op_done), 0);
      cyc();
      rst = 1'b0;
      i_req = 1'b1; i_vaddr = 32'h0040_2000;
      @(negedge clk);
      chk("rm_run_iack", 32'(i_ack), 1);
      chk("rm_run_done", 32'(op_done), 0);
      cyc();
      i_req = 1'b0;
      cyc();
      @(negedge clk);
      chk("rm_run_irv", 32'(i_rvalid), 1);
      chk("rm_run_ipa", i_paddr, 32'h0040_2000 ^ MAP);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
